// File: rtl/rx_hst_ctrl_mch.sv
// Snoops TRN rx MemWr32/MemWr64 on one BAR and commits per-channel lbuf address/enable pairs, held until lbuf_dn.
// Optional ignored-enable counter: define RX_HST_CTRL_MCH_ERRCNT_EN; otherwise err_cnt is tied to 0.
module rx_hst_ctrl_mch #(
  parameter int NUM_LBUF  = 2,
  parameter int BARHIT    = 2,
  parameter int OFFSET_W  = 6,
  parameter int ADDR_BASE = 0,
  parameter int EN_BASE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           trn_rd,
  input  logic [7:0]            trn_rrem_n,
  input  logic                  trn_rsof_n,
  input  logic                  trn_reof_n,
  input  logic                  trn_rsrc_rdy_n,
  input  logic [6:0]            trn_rbar_hit_n,
  output logic [64*NUM_LBUF-1:0] lbuf_addr,
  output logic [NUM_LBUF-1:0]   lbuf_en,
  input  logic [NUM_LBUF-1:0]   lbuf_dn,
  output logic [15:0]           err_cnt
);

  localparam logic [6:0] MEM_WR32 = 7'h40;
  localparam logic [6:0] MEM_WR64 = 7'h60;

  typedef enum logic [2:0] {IDLE, W32, D32, A64, D64, DRAIN} state_t;

  state_t              state, state_nxt;
  logic                beat, sof, eof, bar_hit;
  logic [9:0]          len_q;
  logic [OFFSET_W-1:0] off_q;
  logic                dw0_vld, dw1_vld;
  logic [31:0]         dw0_dat, dw1_dat;
  logic [OFFSET_W-1:0] dw0_off, dw1_off;
  logic [63:0]         shadow_q   [NUM_LBUF];
  logic [63:0]         shadow_nxt [NUM_LBUF];
  logic [NUM_LBUF-1:0] req, en_eff, acc;
  logic                unused_sig;

  assign beat       = ~trn_rsrc_rdy_n;
  assign sof        = ~trn_rsof_n;
  assign eof        = ~trn_reof_n;
  assign bar_hit    = ~trn_rbar_hit_n[BARHIT];
  assign unused_sig = ^{trn_rrem_n, trn_rbar_hit_n};

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      off_q <= '0;
    end else begin
      state <= state_nxt;
      if (beat && state == IDLE && sof) len_q <= trn_rd[41:32];
      if (beat && state == W32)         off_q <= trn_rd[OFFSET_W+33:34];
      if (beat && state == A64)         off_q <= trn_rd[OFFSET_W+1:2];
    end
  end

  // Each beat yields at most two payload DWs; slot 1 always sits at offset+1.
  always_comb begin
    state_nxt = state;
    dw0_vld   = 1'b0;
    dw1_vld   = 1'b0;
    dw0_dat   = trn_rd[31:0];
    dw1_dat   = trn_rd[31:0];
    dw0_off   = off_q;
    dw1_off   = off_q + OFFSET_W'(1);
    if (beat) begin
      case (state)
        IDLE: begin
          if (sof) begin
            if (eof)                              state_nxt = IDLE;
            else if (!bar_hit)                    state_nxt = DRAIN;
            else if (trn_rd[62:56] == MEM_WR32)   state_nxt = W32;
            else if (trn_rd[62:56] == MEM_WR64)   state_nxt = A64;
            else                                  state_nxt = DRAIN;
          end
        end
        W32: begin
          dw0_vld = 1'b1;
          dw0_off = trn_rd[OFFSET_W+33:34];
          if (eof)                 state_nxt = IDLE;
          else if (len_q >= 10'd2) state_nxt = D32;
          else                     state_nxt = DRAIN;
        end
        D32: begin
          dw1_vld   = 1'b1;
          dw1_dat   = trn_rd[63:32];
          state_nxt = eof ? IDLE : DRAIN;
        end
        A64: state_nxt = eof ? IDLE : D64;
        D64: begin
          dw0_vld   = 1'b1;
          dw0_dat   = trn_rd[63:32];
          dw1_vld   = (len_q >= 10'd2);
          state_nxt = eof ? IDLE : DRAIN;
        end
        DRAIN: if (eof) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LBUF; i++) begin
      shadow_nxt[i] = shadow_q[i];
      req[i]        = 1'b0;
      if (dw0_vld && int'(dw0_off) == ADDR_BASE + 2*i)     shadow_nxt[i][31:0]  = bswap(dw0_dat);
      if (dw0_vld && int'(dw0_off) == ADDR_BASE + 2*i + 1) shadow_nxt[i][63:32] = bswap(dw0_dat);
      if (dw1_vld && int'(dw1_off) == ADDR_BASE + 2*i)     shadow_nxt[i][31:0]  = bswap(dw1_dat);
      if (dw1_vld && int'(dw1_off) == ADDR_BASE + 2*i + 1) shadow_nxt[i][63:32] = bswap(dw1_dat);
      if ((dw0_vld && int'(dw0_off) == EN_BASE + i) ||
          (dw1_vld && int'(dw1_off) == EN_BASE + i))
        req[i] = 1'b1;
    end
  end

  // Done clears before a same-cycle request is judged, so dn+EN recommits instead of erroring.
  assign en_eff = lbuf_en & ~lbuf_dn;
  assign acc    = req & ~en_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      lbuf_en   <= '0;
      lbuf_addr <= '0;
      for (int i = 0; i < NUM_LBUF; i++) shadow_q[i] <= '0;
    end else begin
      lbuf_en <= en_eff | req;
      for (int i = 0; i < NUM_LBUF; i++) begin
        shadow_q[i] <= shadow_nxt[i];
        if (acc[i]) lbuf_addr[64*i +: 64] <= shadow_nxt[i];
      end
    end
  end

`ifdef RX_HST_CTRL_MCH_ERRCNT_EN
  logic [NUM_LBUF-1:0] ign;
  logic [4:0]          ign_cnt;
  logic [16:0]         err_sum;

  assign ign = req & en_eff;

  always_comb begin
    ign_cnt = '0;
    for (int i = 0; i < NUM_LBUF; i++) ign_cnt = ign_cnt + 5'(ign[i]);
  end

  assign err_sum = {1'b0, err_cnt} + 17'(ign_cnt);

  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_hst_ctrl_mch.sv
// Directed plus randomized TLP traffic against a transaction-level model of the lbuf register map.
module tb_rx_hst_ctrl_mch;

  localparam int NL = 2;
  localparam logic [6:0] BAR2 = 7'b1111011;
  localparam logic [6:0] BAR0 = 7'b1111110;
  localparam logic [6:0] WR32 = 7'h40;
  localparam logic [6:0] WR64 = 7'h60;
  localparam logic [6:0] RD32 = 7'h00;
  localparam logic [6:0] CPLD = 7'h4A;
`ifdef RX_HST_CTRL_MCH_ERRCNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [63:0]     trn_rd;
  logic [7:0]      trn_rrem_n;
  logic            trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n;
  logic [6:0]      trn_rbar_hit_n;
  logic [64*NL-1:0] lbuf_addr;
  logic [NL-1:0]   lbuf_en;
  logic [NL-1:0]   lbuf_dn;
  logic [15:0]     err_cnt;

  rx_hst_ctrl_mch dut (
    .clk(clk), .rst(rst), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
    .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rbar_hit_n(trn_rbar_hit_n), .lbuf_addr(lbuf_addr), .lbuf_en(lbuf_en),
    .lbuf_dn(lbuf_dn), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   pay [8];
  logic [63:0]   m_shadow [NL];
  logic [63:0]   m_addr [NL];
  logic [NL-1:0] m_en;
  int            m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_en"}, 64'(lbuf_en), 64'(m_en));
    for (int c = 0; c < NL; c++)
      chk($sformatf("%s_addr%0d", tag, c), lbuf_addr[64*c +: 64], m_addr[c]);
    chk({tag, "_err"}, 64'(err_cnt), ERR_ON ? 64'(m_err) : 64'd0);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NL; c++) begin
      m_shadow[c] = '0;
      m_addr[c]   = '0;
    end
    m_en  = '0;
    m_err = 0;
  endtask

  // One register write as seen by software: a DW lands at a DW offset, bytes reversed.
  task automatic apply_dw(input int o, input logic [31:0] d);
    logic [31:0] sw;
    sw = {<<8{d}};
    for (int c = 0; c < NL; c++) begin
      if (o == 2*c)     m_shadow[c][31:0]  = sw;
      if (o == 2*c + 1) m_shadow[c][63:32] = sw;
      if (o == 8 + c) begin
        if (m_en[c]) m_err++;
        else begin
          m_en[c]   = 1'b1;
          m_addr[c] = m_shadow[c];
        end
      end
    end
  endtask

  task automatic pulse_dn(input logic [NL-1:0] mask);
    lbuf_dn = mask;
    @(posedge clk); #1;
    lbuf_dn = '0;
    m_en &= ~mask;
  endtask

  // Sends one TLP (payload from pay[]) and updates the model. dn_last rides on the final beat.
  task automatic tlp(input logic [6:0] bar_n, input logic [6:0] ft, input int off, input int len,
                     input int gap, input logic [NL-1:0] dn_last, input int rst_beat);
    logic [31:0] dws [$];
    logic [31:0] a;
    int nb, n_idle;
    dws.push_back({1'b0, ft, 14'h0, 10'(len)});
    dws.push_back($urandom);
    a = $urandom;
    a[7:2] = 6'(off);
    a[1:0] = 2'b00;
    if (ft[5]) dws.push_back($urandom);
    dws.push_back(a);
    if (ft[6]) for (int k = 0; k < len; k++) dws.push_back(pay[k]);
    if (dws.size() % 2 != 0) dws.push_back($urandom);
    nb = dws.size() / 2;
    for (int b = 0; b < nb; b++) begin
      n_idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < n_idle; j++) begin
        trn_rsrc_rdy_n = 1'b1;
        trn_rd         = {$urandom, $urandom};
        trn_rsof_n     = 1'($urandom);
        trn_reof_n     = 1'($urandom);
        trn_rbar_hit_n = 7'($urandom);
        @(posedge clk); #1;
      end
      trn_rd         = {dws[2*b], dws[2*b+1]};
      trn_rsof_n     = (b != 0);
      trn_reof_n     = (b != nb - 1);
      trn_rbar_hit_n = bar_n;
      trn_rsrc_rdy_n = 1'b0;
      if (b == nb - 1) lbuf_dn = dn_last;
      if (b == rst_beat) rst = 1'b1;
      @(posedge clk); #1;
      rst            = 1'b0;
      lbuf_dn        = '0;
      trn_rsrc_rdy_n = 1'b1;
    end
    if (rst_beat >= 0) model_reset();
    else begin
      m_en &= ~dn_last;
      if (!bar_n[2] && (ft == WR32 || ft == WR64))
        for (int k = 0; k < len && k < 2; k++) apply_dw((off + k) % 64, pay[k]);
    end
  endtask

  initial begin
    logic [6:0] ft, bn;
    int r;
    rst = 1'b1; trn_rd = '0; trn_rrem_n = '0; trn_rsof_n = 1'b1; trn_reof_n = 1'b1;
    trn_rsrc_rdy_n = 1'b1; trn_rbar_hit_n = 7'h7F; lbuf_dn = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset");

    // Channel 0 address then enable; enable must be visible one cycle after the EN beat
    pay[0] = 32'h78563412; pay[1] = 32'hF0DEBC9A;
    tlp(BAR2, WR32, 0, 2, 0, '0, -1);
    check_all("t1_shadow_only");
    pay[0] = $urandom;
    tlp(BAR2, WR32, 8, 1, 0, '0, -1);
    chk("t1_en0_next_cycle", 64'(lbuf_en[0]), 64'd1);
    chk("t1_addr0_const", lbuf_addr[63:0], 64'h9ABCDEF012345678);
    check_all("t1");

    // Channel 1 via MemWr64 with a not-ready cycle before every beat
    pay[0] = 32'h44332211; pay[1] = 32'h88776655;
    tlp(BAR2, WR64, 2, 2, 1, '0, -1);
    pay[0] = $urandom;
    tlp(BAR2, WR32, 9, 1, 1, '0, -1);
    chk("t2_addr1_const", lbuf_addr[127:64], 64'h5566778811223344);
    check_all("t2");

    // Enable while busy is ignored and counted
    pay[0] = 32'hDDCCBBAA;
    tlp(BAR2, WR32, 0, 1, 0, '0, -1);
    pay[0] = $urandom;
    tlp(BAR2, WR32, 8, 1, 0, '0, -1);
    chk("t3_addr0_held", lbuf_addr[63:0], 64'h9ABCDEF012345678);
    check_all("t3");

    // Done and enable on the same cycle recommit the new shadow
    pay[0] = $urandom;
    tlp(BAR2, WR32, 8, 1, 0, 2'b01, -1);
    chk("t4_en0_kept", 64'(lbuf_en[0]), 64'd1);
    chk("t4_addr0_new", lbuf_addr[63:0], 64'h9ABCDEF0AABBCCDD);
    check_all("t4");

    // Filtered traffic, then a long write of which only two DWs count
    pulse_dn(2'b01);
    check_all("t5_dn");
    pay[0] = $urandom;
    tlp(BAR0, WR32, 8, 1, 0, '0, -1);
    tlp(BAR2, RD32, 8, 1, 0, '0, -1);
    check_all("t5_filtered");
    for (int k = 0; k < 4; k++) pay[k] = $urandom;
    tlp(BAR2, WR32, 8, 4, 2, '0, -1);
    check_all("t5_len4_en");
    for (int k = 0; k < 4; k++) pay[k] = $urandom;
    tlp(BAR2, WR32, 0, 4, 0, '0, -1);
    pulse_dn(2'b11);
    pay[0] = $urandom;
    tlp(BAR2, WR32, 9, 1, 0, '0, -1);
    chk("t5_discard_addr1", lbuf_addr[127:64], 64'h5566778811223344);
    check_all("t5");

    // Reset in the middle of a MemWr64 data beat
    for (int k = 0; k < 4; k++) pay[k] = $urandom;
    tlp(BAR2, WR64, 0, 4, 0, '0, 2);
    chk("t6_en_zero", 64'(lbuf_en), 64'd0);
    check_all("t6_rst");
    pay[0] = 32'h0DF0ADDE; pay[1] = 32'hBEBAFECA;
    tlp(BAR2, WR32, 2, 2, 0, '0, -1);
    pay[0] = $urandom;
    tlp(BAR2, WR32, 9, 1, 0, '0, -1);
    chk("t6_addr1_after", lbuf_addr[127:64], 64'hCAFEBABEDEADF00D);
    check_all("t6");

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      ft = (r < 4) ? WR32 : (r < 8) ? WR64 : (r == 8) ? RD32 : CPLD;
      bn = 7'($urandom);
      bn[2] = ($urandom_range(0, 99) < 85) ? 1'b0 : 1'b1;
      for (int k = 0; k < 8; k++) pay[k] = $urandom;
      tlp(bn, ft, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 11)),
          $urandom_range(1, 5), $urandom_range(0, 2), '0, -1);
      check_all($sformatf("rnd%0d", it));
      if ($urandom_range(0, 9) < 3) pulse_dn(NL'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
